// File: rtl/rem_param.sv
// Memory address register for the SAP datapath: run-mode address from the bus,
// program-mode pointer from the switches, guarded registered mux onto the RAM address.
module rem_param #(
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RESET_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              Lm,
    input  logic              run_prog,
    input  logic              prog_load,
    input  logic              prog_step,
    output logic [ADDR_W-1:0] Y_ram,
    output logic              addr_valid,
    output logic              mode_run,
    output logic              err_oob
);

    localparam logic [1:0] S_PROG    = 2'd0;
    localparam logic [1:0] S_SW_RUN  = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_SW_PROG = 2'd3;

    // DEPTH may equal 2**ADDR_W, so range checks use one extra bit
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [ADDR_W-1:0] run_addr;
    logic [ADDR_W-1:0] prog_addr;
    logic              bus_ok;
    logic              ain_ok;
    logic              in_prog;
    logic              run_try;
    logic              prog_try;

    assign bus_ok   = {1'b0, bus} < LIMIT;
    assign ain_ok   = {1'b0, addr_in} < LIMIT;
    assign in_prog  = (state == S_PROG);
    assign run_try  = !Lm;
    assign prog_try = in_prog && prog_load;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_PROG:    state_nx = run_prog ? S_SW_RUN : S_PROG;
            S_SW_RUN:  state_nx = run_prog ? S_RUN : S_PROG;
            S_RUN:     state_nx = run_prog ? S_RUN : S_SW_PROG;
            S_SW_PROG: state_nx = run_prog ? S_RUN : S_PROG;
            default:   state_nx = S_PROG;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_PROG;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_addr <= RST_A;
        end else if (run_try && bus_ok) begin
            run_addr <= bus;
        end
    end

    // load beats step; a rejected load also suppresses the step
    always_ff @(posedge clock) begin
        if (reset) begin
            prog_addr <= RST_A;
        end else if (in_prog) begin
            if (prog_load) begin
                if (ain_ok) begin
                    prog_addr <= addr_in;
                end
            end else if (prog_step) begin
                if (prog_addr == LAST) begin
                    prog_addr <= '0;
                end else begin
                    prog_addr <= prog_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Y_ram      <= RST_A;
            addr_valid <= 1'b0;
        end else begin
            unique case (state)
                S_PROG: begin
                    Y_ram      <= prog_addr;
                    addr_valid <= 1'b1;
                end
                S_RUN: begin
                    Y_ram      <= run_addr;
                    addr_valid <= 1'b1;
                end
                default: begin
                    addr_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_run <= 1'b0;
            err_oob  <= 1'b0;
        end else begin
            mode_run <= (state_nx == S_RUN);
            err_oob  <= (run_try && !bus_ok) || (prog_try && !ain_ok);
        end
    end

endmodule

// File: tb/tb_rem_param.sv
// Directed bench for rem_param: two depths driven in parallel, checked every
// cycle against a mode/bubble model plus hand-computed spot values.
module tb_rem_param;

    logic       clk;
    logic       reset;
    logic [3:0] bus;
    logic [3:0] addr_in;
    logic       Lm;
    logic       run_prog;
    logic       prog_load;
    logic       prog_step;

    logic [3:0] y16, y12;
    logic       v16, v12;
    logic       r16, r12;
    logic       e16, e12;

    int checks = 0;
    int errors = 0;

    rem_param #(.ADDR_W(4), .DEPTH(16), .RESET_ADDR(0)) u16 (
        .clock(clk), .reset(reset), .bus(bus), .addr_in(addr_in),
        .Lm(Lm), .run_prog(run_prog), .prog_load(prog_load),
        .prog_step(prog_step), .Y_ram(y16), .addr_valid(v16),
        .mode_run(r16), .err_oob(e16)
    );

    rem_param #(.ADDR_W(4), .DEPTH(12), .RESET_ADDR(0)) u12 (
        .clock(clk), .reset(reset), .bus(bus), .addr_in(addr_in),
        .Lm(Lm), .run_prog(run_prog), .prog_load(prog_load),
        .prog_step(prog_step), .Y_ram(y12), .addr_valid(v12),
        .mode_run(r12), .err_oob(e12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: settled mode (run) plus a bubble flag (sw)
    int dep [2] = '{16, 12};
    int m_ra [2];
    int m_pa [2];
    int m_y  [2];
    bit m_v  [2];
    bit m_mr [2];
    bit m_er [2];
    bit m_run[2];
    bit m_sw [2];
    bit m_prog;
    bit started = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ra[i] = 0; m_pa[i] = 0; m_y[i] = 0;
                m_v[i] = 0; m_mr[i] = 0; m_er[i] = 0;
                m_run[i] = 0; m_sw[i] = 0;
            end else begin
                m_prog = !m_run[i] && !m_sw[i];
                m_er[i] = (!Lm && bus >= dep[i])
                       || (m_prog && prog_load && addr_in >= dep[i]);
                m_v[i] = !m_sw[i];
                if (!m_sw[i]) m_y[i] = m_run[i] ? m_ra[i] : m_pa[i];
                if (!Lm && bus < dep[i]) m_ra[i] = bus;
                if (m_prog) begin
                    if (prog_load) begin
                        if (addr_in < dep[i]) m_pa[i] = addr_in;
                    end else if (prog_step) begin
                        m_pa[i] = (m_pa[i] + 1) % dep[i];
                    end
                end
                if (m_sw[i]) begin
                    m_run[i] = run_prog;
                    m_sw[i] = 0;
                end else if (run_prog != m_run[i]) begin
                    m_sw[i] = 1;
                end
                m_mr[i] = m_run[i] && !m_sw[i];
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m16.y", y16, m_y[0]);
            chk("m16.valid", v16, m_v[0]);
            chk("m16.mode_run", r16, m_mr[0]);
            chk("m16.err", e16, m_er[0]);
            chk("m12.y", y12, m_y[1]);
            chk("m12.valid", v12, m_v[1]);
            chk("m12.mode_run", r12, m_mr[1]);
            chk("m12.err", e12, m_er[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1; bus = 0; addr_in = 0; Lm = 1;
        run_prog = 0; prog_load = 0; prog_step = 0;
        cyc(2);
        chk("rst.y", y16, 0);
        chk("rst.valid", v16, 0);
        reset = 0;
        cyc(1);
        chk("t1.y", y16, 0);
        chk("t1.valid", v16, 1);
        chk("t1.mode_run", r16, 0);

        prog_load = 1; addr_in = 5;
        cyc(1);
        prog_load = 0; prog_step = 1;
        cyc(1);
        chk("t2.y_first", y16, 5);
        cyc(10);
        prog_step = 0;
        cyc(1);
        chk("t2.wrap16", y16, 0);
        chk("t2.wrap12", y12, 4);

        Lm = 0; bus = 3;
        cyc(1);
        Lm = 1; run_prog = 1;
        cyc(1);
        chk("t3.valid_a", v16, 1);
        cyc(1);
        chk("t3.valid_a1", v16, 0);
        cyc(1);
        chk("t3.y_a2", y16, 3);
        chk("t3.valid_a2", v16, 1);
        chk("t3.mode_run_a2", r16, 1);

        Lm = 0; bus = 9;
        cyc(1);
        Lm = 1;
        cyc(1);
        chk("t4.y9", y12, 9);
        Lm = 0; bus = 13;
        cyc(1);
        Lm = 1;
        chk("t4.err12", e12, 1);
        chk("t4.err16", e16, 0);
        cyc(1);
        chk("t4.err12_off", e12, 0);
        chk("t4.y12_hold", y12, 9);
        chk("t4.y16_13", y16, 13);

        run_prog = 0;
        cyc(3);
        chk("t5.pre_mode", r16, 0);
        run_prog = 1;
        cyc(1);
        run_prog = 0;
        chk("t5.valid0", v16, 1);
        cyc(1);
        chk("t5.valid1", v16, 0);
        chk("t5.mode1", r16, 0);
        cyc(1);
        chk("t5.valid2", v16, 1);
        chk("t5.mode2", r12, 0);
        chk("t5.pa16", y16, 0);
        chk("t5.pa12", y12, 4);

        Lm = 0; bus = 7;
        cyc(1);
        Lm = 1; run_prog = 1;
        cyc(3);
        chk("t6.run_y", y16, 7);
        run_prog = 0;
        cyc(1);
        reset = 1; run_prog = 1;
        cyc(1);
        chk("t6.rst_y", y16, 0);
        chk("t6.rst_valid", v16, 0);
        chk("t6.rst_mode", r16, 0);
        reset = 0;
        cyc(1);
        chk("t6.prog_valid", v16, 1);
        chk("t6.prog_mode", r16, 0);
        cyc(1);
        chk("t6.sw_valid", v16, 0);
        cyc(1);
        chk("t6.run_valid", v16, 1);
        chk("t6.run_mode", r16, 1);
        chk("t6.run_y0", y16, 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
